// File: rtl/netbus_pkg.sv
// Shared NetBus definitions: flit geometry, port count and the transmit-router state encoding.
package netbus_pkg;

    localparam int LAST_BIT     = 0;
    localparam int DEST_LSB     = 1;
    localparam int DEST_W       = 3;
    localparam int NUM_TX_PORTS = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    function automatic int flit_width(input int data_width);
        return data_width * 9 + 14;
    endfunction

endpackage

// File: rtl/netbus_tx_slot.sv
// One-entry registered output slot: a load always wins, otherwise a downstream ready empties it.
module netbus_tx_slot
    import netbus_pkg::*;
#(
    parameter int W = flit_width(4)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/netbus_tx_route6.sv
// NetBus transmit router: steers whole frames from one flit stream to six slots, dropping bad destinations.
// Optional frame/drop counters are built when NETBUS_TX_STATS_EN is defined.
module netbus_tx_route6
    import netbus_pkg::*;
#(
    parameter  int DATA_WIDTH = 4,
    localparam int W          = flit_width(DATA_WIDTH)
) (
    input  logic         TCLK,
    input  logic         RESETn,
    input  logic [W-1:0] WDATA,
    input  logic         WVALID,
    output logic         WREADY,
    output logic [W-1:0] TDATA0,
    output logic [W-1:0] TDATA1,
    output logic [W-1:0] TDATA2,
    output logic [W-1:0] TDATA3,
    output logic [W-1:0] TDATA4,
    output logic [W-1:0] TDATA5,
    output logic         TVALID0,
    output logic         TVALID1,
    output logic         TVALID2,
    output logic         TVALID3,
    output logic         TVALID4,
    output logic         TVALID5,
    input  logic         TREADY0,
    input  logic         TREADY1,
    input  logic         TREADY2,
    input  logic         TREADY3,
    input  logic         TREADY4,
    input  logic         TREADY5
`ifdef NETBUS_TX_STATS_EN
    ,
    output logic [15:0]  FRAME_CNT,
    output logic [15:0]  DROP_CNT
`endif
);

    localparam int DEST_SPAN = 2 ** DEST_W;

    state_t                  state_q, state_d;
    logic [DEST_W-1:0]       port_sel_q, port_sel_d;
    logic [DEST_W-1:0]       hdr_dest, dest_eff;
    logic                    hdr_ok, fwd_phase, accept, is_last;
    logic [NUM_TX_PORTS-1:0] tready_v, tvalid_v, load_v;
    logic [DEST_SPAN-1:0]    free_v;
    logic [W-1:0]            tdata_v [NUM_TX_PORTS];

    assign tready_v = {TREADY5, TREADY4, TREADY3, TREADY2, TREADY1, TREADY0};
    assign hdr_dest = WDATA[DEST_LSB +: DEST_W];
    assign hdr_ok   = hdr_dest < DEST_W'(NUM_TX_PORTS);
    assign is_last  = WDATA[LAST_BIT];
    assign dest_eff = (state_q == FWD) ? port_sel_q : hdr_dest;

    // Padded so out-of-range header destinations index a defined (unused) bit.
    assign free_v    = {{(DEST_SPAN - NUM_TX_PORTS){1'b0}}, ~tvalid_v | tready_v};
    assign fwd_phase = (state_q == FWD) || (state_q == IDLE && hdr_ok);
    assign WREADY    = RESETn && (fwd_phase ? free_v[dest_eff] : 1'b1);
    assign accept    = WVALID && WREADY;

    always_comb begin
        state_d    = state_q;
        port_sel_d = port_sel_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (!is_last) begin
                        if (hdr_ok) begin
                            state_d    = FWD;
                            port_sel_d = hdr_dest;
                        end else begin
                            state_d = DROP;
                        end
                    end
                end
                FWD, DROP: begin
                    if (is_last) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge TCLK) begin
        if (!RESETn) begin
            state_q    <= IDLE;
            port_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            port_sel_q <= port_sel_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_TX_PORTS; gi++) begin : g_slot
            assign load_v[gi] = accept && fwd_phase && (dest_eff == DEST_W'(gi));

            netbus_tx_slot #(.W(W)) u_slot (
                .clk       (TCLK),
                .rst_n     (RESETn),
                .load      (load_v[gi]),
                .load_data (WDATA),
                .ready     (tready_v[gi]),
                .valid     (tvalid_v[gi]),
                .data      (tdata_v[gi])
            );
        end
    endgenerate

    assign {TVALID5, TVALID4, TVALID3, TVALID2, TVALID1, TVALID0} = tvalid_v;
    assign TDATA0 = tdata_v[0];
    assign TDATA1 = tdata_v[1];
    assign TDATA2 = tdata_v[2];
    assign TDATA3 = tdata_v[3];
    assign TDATA4 = tdata_v[4];
    assign TDATA5 = tdata_v[5];

`ifdef NETBUS_TX_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // A frame is counted once, on its accepted LAST flit; both counters stick at all-ones.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (accept && is_last) begin
            if (fwd_phase) begin
                if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
                if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge TCLK) begin
        if (!RESETn) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign FRAME_CNT = frame_cnt_q;
    assign DROP_CNT  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_netbus_tx_route6.sv
// Scoreboard bench for netbus_tx_route6; stats checks are compiled in with NETBUS_TX_STATS_EN.
module tb_netbus_tx_route6;

    localparam int W = 4 * 9 + 14;

    typedef struct {
        int           port;
        logic [W-1:0] data;
    } exp_t;

    logic         TCLK = 1'b0;
    logic         RESETn;
    logic [W-1:0] WDATA;
    logic         WVALID;
    logic         WREADY;
    logic [5:0]   tr;
    logic [5:0]   tv;
    logic [W-1:0] td [6];
    logic [W-1:0] TDATA0, TDATA1, TDATA2, TDATA3, TDATA4, TDATA5;
    logic         TVALID0, TVALID1, TVALID2, TVALID3, TVALID4, TVALID5;
`ifdef NETBUS_TX_STATS_EN
    logic [15:0]  FRAME_CNT, DROP_CNT;
`endif

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cur_port = -1;
    logic acc_flag = 1'b0;
    int   last_waits = 0;
    int   frames_exp = 0;
    int   drops_exp = 0;

    always #5 TCLK = ~TCLK;

    assign tv = {TVALID5, TVALID4, TVALID3, TVALID2, TVALID1, TVALID0};
    assign td[0] = TDATA0;
    assign td[1] = TDATA1;
    assign td[2] = TDATA2;
    assign td[3] = TDATA3;
    assign td[4] = TDATA4;
    assign td[5] = TDATA5;

    netbus_tx_route6 #(.DATA_WIDTH(4)) dut (
        .TCLK    (TCLK),
        .RESETn  (RESETn),
        .WDATA   (WDATA),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .TDATA0  (TDATA0),
        .TDATA1  (TDATA1),
        .TDATA2  (TDATA2),
        .TDATA3  (TDATA3),
        .TDATA4  (TDATA4),
        .TDATA5  (TDATA5),
        .TVALID0 (TVALID0),
        .TVALID1 (TVALID1),
        .TVALID2 (TVALID2),
        .TVALID3 (TVALID3),
        .TVALID4 (TVALID4),
        .TVALID5 (TVALID5),
        .TREADY0 (tr[0]),
        .TREADY1 (tr[1]),
        .TREADY2 (tr[2]),
        .TREADY3 (tr[3]),
        .TREADY4 (tr[4]),
        .TREADY5 (tr[5])
`ifdef NETBUS_TX_STATS_EN
        ,
        .FRAME_CNT (FRAME_CNT),
        .DROP_CNT  (DROP_CNT)
`endif
    );

    // Pop output handshakes against the scoreboard and push the flit being accepted this cycle.
    task automatic observe();
        for (int p = 0; p < 6; p++) begin
            if (tv[p] && tr[p]) begin
                int idx;
                idx = -1;
                for (int i = 0; i < exp_q.size(); i++)
                    if (idx < 0 && exp_q[i].port == p) idx = i;
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL out_port%0d: got unexpected flit %h, required none", p, td[p]);
                end else begin
                    if (td[p] !== exp_q[idx].data) begin
                        errors++;
                        $display("FAIL out_port%0d: got %h, required %h", p, td[p], exp_q[idx].data);
                    end else begin
                        $display("port%0d flit %h ok", p, td[p]);
                    end
                    exp_q.delete(idx);
                end
            end
        end
        acc_flag = WVALID && WREADY;
        if (acc_flag && cur_port >= 0) exp_q.push_back('{cur_port, WDATA});
    endtask

    task automatic tick();
        @(negedge TCLK);
        observe();
        @(posedge TCLK);
        #1;
    endtask

    function automatic logic [W-1:0] make_flit(input logic [2:0] dest, input logic last);
        logic [63:0]  r;
        logic [W-1:0] f;
        r = {$urandom(), $urandom()};
        f = r[W-1:0];
        f[3:1] = dest;
        f[0] = last;
        return f;
    endfunction

    task automatic send_flit(input logic [W-1:0] data, input int port);
        WDATA = data;
        WVALID = 1'b1;
        cur_port = port;
        last_waits = 0;
        acc_flag = 1'b0;
        while (!acc_flag && last_waits < 100) begin
            tick();
            last_waits++;
        end
        if (!acc_flag) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: flit %h not accepted in %0d cycles, required acceptance", data, last_waits);
        end
        WVALID = 1'b0;
        cur_port = -1;
    endtask

    task automatic send_frame(input int dest, input int nflits, input logic chk_rate);
        int port;
        port = (dest < 6) ? dest : -1;
        for (int i = 0; i < nflits; i++) begin
            logic [2:0] d;
            d = (i == 0) ? 3'(dest) : 3'($urandom_range(0, 7));
            send_flit(make_flit(d, i == nflits - 1), port);
            if (chk_rate) begin
                checks++;
                if (last_waits != 1) begin
                    errors++;
                    $display("FAIL rate dest%0d flit%0d: took %0d cycles, required 1", dest, i, last_waits);
                end
            end
        end
        if (port >= 0) frames_exp = (frames_exp < 65535) ? frames_exp + 1 : 65535;
        else           drops_exp  = (drops_exp  < 65535) ? drops_exp  + 1 : 65535;
        $display("frame dest=%0d flits=%0d sent", dest, nflits);
    endtask

    task automatic drain_check(input string name);
        tr = 6'h3F;
        WVALID = 1'b0;
        repeat (4) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: %0d flits outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        WVALID = 1'b0;
        WDATA = '0;
        tr = 6'h3F;
        repeat (2) begin @(posedge TCLK); #1; end
        @(negedge TCLK);
        checks++;
        if (WREADY !== 1'b0 || tv !== 6'h00) begin
            errors++;
            $display("FAIL reset_outputs: WREADY=%b TVALID=%b, required 0 and 000000", WREADY, tv);
        end
        for (int p = 0; p < 6; p++) begin
            checks++;
            if (td[p] !== '0) begin
                errors++;
                $display("FAIL reset_tdata%0d: got %h, required 0", p, td[p]);
            end
        end
        @(posedge TCLK); #1;
        RESETn = 1'b1;
        @(negedge TCLK);
        checks++;
        if (WREADY !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_wready: got %b, required 1", WREADY);
        end
        @(posedge TCLK); #1;
        $display("reset test done");
    endtask

    task automatic test_single();
        logic [W-1:0] f;
        f = make_flit(3'd2, 1'b1);
        send_flit(f, 2);
        frames_exp++;
        @(negedge TCLK);
        checks++;
        if (tv !== 6'b000100 || td[2] !== f) begin
            errors++;
            $display("FAIL single_latency: TVALID=%b TDATA2=%h, required 000100 and %h", tv, td[2], f);
        end
        observe();
        @(posedge TCLK); #1;
        send_frame(4, 1, 1'b1);
        drain_check("single");
    endtask

    task automatic test_stall();
        logic [W-1:0] f2;
        send_flit(make_flit(3'd5, 1'b0), 5);
        send_flit(make_flit(3'd1, 1'b0), 5);
        tr[5] = 1'b0;
        f2 = make_flit(3'd0, 1'b0);
        WDATA = f2;
        WVALID = 1'b1;
        cur_port = 5;
        for (int k = 0; k < 3; k++) begin
            @(negedge TCLK);
            checks++;
            if (WREADY !== 1'b0 || tv[5] !== 1'b1) begin
                errors++;
                $display("FAIL stall_wready cyc%0d: WREADY=%b TVALID5=%b, required 0 and 1", k, WREADY, tv[5]);
            end
            observe();
            @(posedge TCLK); #1;
        end
        tr[5] = 1'b1;
        send_flit(f2, 5);
        send_flit(make_flit(3'd7, 1'b1), 5);
        frames_exp++;
        drain_check("stall");
    endtask

    task automatic test_drop();
        send_frame(7, 3, 1'b1);
        @(negedge TCLK);
        checks++;
        if (tv !== 6'h00) begin
            errors++;
            $display("FAIL drop_no_valid: TVALID=%b, required 000000", tv);
        end
        observe();
        @(posedge TCLK); #1;
        send_frame(6, 1, 1'b1);
`ifdef NETBUS_TX_STATS_EN
        checks++;
        if (DROP_CNT !== 16'(drops_exp) || FRAME_CNT !== 16'(frames_exp)) begin
            errors++;
            $display("FAIL drop_stats: DROP_CNT=%0d FRAME_CNT=%0d, required %0d and %0d",
                     DROP_CNT, FRAME_CNT, drops_exp, frames_exp);
        end
`endif
        drain_check("drop");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1;
        tr[0] = 1'b0;
        tr[3] = 1'b0;
        send_flit(make_flit(3'd0, 1'b0), 0);
        a1 = make_flit(3'd3, 1'b1);
        WDATA = a1;
        WVALID = 1'b1;
        cur_port = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge TCLK);
            checks++;
            if (WREADY !== 1'b0 || tv[3] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_stall cyc%0d: WREADY=%b TVALID3=%b, required 0 and 0", k, WREADY, tv[3]);
            end
            observe();
            @(posedge TCLK); #1;
        end
        tr[0] = 1'b1;
        send_flit(a1, 0);
        frames_exp++;
        send_flit(make_flit(3'd3, 1'b0), 3);
        tr[3] = 1'b1;
        send_flit(make_flit(3'd0, 1'b1), 3);
        frames_exp++;
        drain_check("b2b");
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] f;
        tr[1] = 1'b0;
        send_flit(make_flit(3'd1, 1'b0), 1);
        RESETn = 1'b0;
        @(negedge TCLK);
        checks++;
        if (WREADY !== 1'b0) begin
            errors++;
            $display("FAIL midreset_wready: got %b, required 0", WREADY);
        end
        @(posedge TCLK); #1;
        RESETn = 1'b1;
        exp_q.delete();
        frames_exp = 0;
        drops_exp = 0;
        @(negedge TCLK);
        checks++;
        if (tv !== 6'h00 || td[1] !== '0) begin
            errors++;
            $display("FAIL midreset_clear: TVALID=%b TDATA1=%h, required 000000 and 0", tv, td[1]);
        end
        @(posedge TCLK); #1;
        tr[1] = 1'b1;
        f = make_flit(3'd4, 1'b1);
        send_flit(f, 4);
        frames_exp++;
        @(negedge TCLK);
        checks++;
        if (tv !== 6'b010000 || td[4] !== f) begin
            errors++;
            $display("FAIL midreset_header: TVALID=%b TDATA4=%h, required 010000 and %h", tv, td[4], f);
        end
        observe();
        @(posedge TCLK); #1;
        drain_check("midreset");
    endtask

`ifdef NETBUS_TX_STATS_EN
    task automatic test_saturation();
        for (int n = 0; n < 65536; n++) send_frame(0, 1, 1'b0);
        drain_check("saturation");
        checks++;
        if (FRAME_CNT !== 16'hFFFF || DROP_CNT !== 16'(drops_exp)) begin
            errors++;
            $display("FAIL stats_saturate: FRAME_CNT=%h DROP_CNT=%0d, required ffff and %0d",
                     FRAME_CNT, DROP_CNT, drops_exp);
        end
        $display("saturation test done FRAME_CNT=%h", FRAME_CNT);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_drop();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef NETBUS_TX_STATS_EN
        test_saturation();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
